// File: rtl/rca_nbit_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The producer side drives operands; the adder side returns registered results.
interface rca_nbit_adder_if #(
    parameter int N = 32
);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] s;
    logic         cout;

    modport master (
        output a, b, cin,
        input  s, cout
    );

    modport slave (
        input  a, b, cin,
        output s, cout
    );
endinterface

// File: rtl/rca_nbit_adder.sv
// N-bit ripple-carry adder built from one-bit full-adder cells,
// with sum and carry-out captured in output registers.
module rca_nbit_adder #(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst,
    rca_nbit_adder_if.slave  bus
);
    logic [N:0]   c;
    logic [N-1:0] sum;
    logic [N-1:0] s_d;
    logic [N-1:0] s_q;
    logic         cout_d;
    logic         cout_q;

    assign c[0] = bus.cin;

    // Carry ripples strictly LSB to MSB through one cell per bit.
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i] = bus.a[i] ^ bus.b[i] ^ c[i];
        assign c[i+1] = (bus.a[i] & bus.b[i])
                      | (bus.a[i] & c[i])
                      | (bus.b[i] & c[i]);
    end

    assign s_d    = sum;
    assign cout_d = c[N];

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign bus.s    = s_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_rca_nbit_adder.sv
// Directed and randomised checks of the registered ripple-carry adder
// at widths 32, 8 and 1.
module tb_rca_nbit_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    rca_nbit_adder_if #(.N(32)) if32 ();
    rca_nbit_adder_if #(.N(8))  if8  ();
    rca_nbit_adder_if #(.N(1))  if1  ();

    rca_nbit_adder #(.N(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    rca_nbit_adder #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    rca_nbit_adder #(.N(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));

    task automatic drive32(input logic [31:0] a, input logic [31:0] b,
                           input logic c);
        if32.a   = a;
        if32.b   = b;
        if32.cin = c;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive32(32'd16, 32'd15, 1'b0);
        if8.a = 8'hff; if8.b = 8'h01; if8.cin = 1'b1;
        if1.a = 1'b1;  if1.b = 1'b1;  if1.cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (if32.s !== 32'd0 || if32.cout !== 1'b0)
            $display("FAIL reset32: s=%h cout=%b want s=0 cout=0",
                     if32.s, if32.cout);
        else passed++;
        total++;
        if (if8.s !== 8'd0 || if8.cout !== 1'b0)
            $display("FAIL reset8: s=%h cout=%b want s=0 cout=0",
                     if8.s, if8.cout);
        else passed++;
        total++;
        if (if1.s !== 1'b0 || if1.cout !== 1'b0)
            $display("FAIL reset1: s=%h cout=%b want s=0 cout=0",
                     if1.s, if1.cout);
        else passed++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (if32.s !== 32'd31 || if32.cout !== 1'b0)
            $display("FAIL reset_release: s=%0d cout=%b want s=31 cout=0",
                     if32.s, if32.cout);
        else passed++;
        total++;
        if (if8.s !== 8'h01 || if8.cout !== 1'b1)
            $display("FAIL reset_release8: s=%h cout=%b want s=01 cout=1",
                     if8.s, if8.cout);
        else passed++;
    endtask

    task automatic test_vectors(input string name);
        logic [31:0] va [12];
        logic [31:0] vb [12];
        logic        vc [12];
        logic [31:0] es [12];
        logic        ec [12];
        va = '{32'd16, 32'd0, 32'd36, 32'd255, 32'd31, 32'd131072,
               32'd256, 32'hffffffff, 32'hffffffff, 32'h80000000,
               32'd0, 32'hffffffff};
        vb = '{32'd0, 32'd16, 32'd63, 32'd15, 32'd65536, 32'd131072,
               32'd256, 32'd0, 32'hffffffff, 32'h80000000,
               32'd0, 32'hffffffff};
        vc = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        es = '{32'd16, 32'd17, 32'd100, 32'd270, 32'd65567, 32'd262144,
               32'd512, 32'd0, 32'hffffffff, 32'd0,
               32'd0, 32'hfffffffe};
        ec = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            drive32(va[i], vb[i], vc[i]);
            @(posedge clk);
            #1;
            total++;
            if (if32.s !== es[i] || if32.cout !== ec[i])
                $display("FAIL %s[%0d]: s=%h cout=%b want s=%h cout=%b",
                         name, i, if32.s, if32.cout, es[i], ec[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic        vc [5];
        logic [31:0] es [5];
        logic        ec [5];
        va = '{32'd1, 32'hfffffffe, 32'd1000, 32'h7fffffff, 32'd5};
        vb = '{32'd2, 32'd1, 32'd24, 32'h80000000, 32'd5};
        vc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        es = '{32'd3, 32'd0, 32'd1024, 32'd0, 32'd11};
        ec = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive32(va[i], vb[i], vc[i]);
            if (i > 0) begin
                #1;
                total++;
                if (if32.s !== es[i-1] || if32.cout !== ec[i-1])
                    $display("FAIL b2b_hold[%0d]: s=%h cout=%b want s=%h cout=%b",
                             i, if32.s, if32.cout, es[i-1], ec[i-1]);
                else passed++;
            end
            @(posedge clk);
            #1;
            total++;
            if (if32.s !== es[i] || if32.cout !== ec[i])
                $display("FAIL b2b[%0d]: s=%h cout=%b want s=%h cout=%b",
                         i, if32.s, if32.cout, es[i], ec[i]);
            else passed++;
        end
        rst = 1'b1;
        drive32(32'd100, 32'd200, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if (if32.s !== 32'd0 || if32.cout !== 1'b0)
            $display("FAIL mid_reset: s=%h cout=%b want s=0 cout=0",
                     if32.s, if32.cout);
        else passed++;
        rst = 1'b0;
        drive32(32'd7, 32'd8, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if (if32.s !== 32'd16 || if32.cout !== 1'b0)
            $display("FAIL resume: s=%0d cout=%b want s=16 cout=0",
                     if32.s, if32.cout);
        else passed++;
    endtask

    task automatic test_sweep();
        logic [31:0] a32, b32;
        logic [7:0]  a8, b8;
        logic        a1, b1, c32, c8, c1;
        logic [32:0] e32;
        logic [8:0]  e8;
        logic [1:0]  e1;
        for (int i = 0; i < 1000; i++) begin
            a32 = $urandom; b32 = $urandom; c32 = 1'($urandom_range(1));
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom_range(1));
            a1 = 1'($urandom_range(1)); b1 = 1'($urandom_range(1));
            c1 = 1'($urandom_range(1));
            drive32(a32, b32, c32);
            if8.a = a8; if8.b = b8; if8.cin = c8;
            if1.a = a1; if1.b = b1; if1.cin = c1;
            e32 = {1'b0, a32} + {1'b0, b32} + {32'd0, c32};
            e8  = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
            e1  = {1'b0, a1} + {1'b0, b1} + {1'b0, c1};
            @(posedge clk);
            #1;
            total++;
            if ({if32.cout, if32.s} !== e32)
                $display("FAIL sweep32[%0d]: got %h want %h",
                         i, {if32.cout, if32.s}, e32);
            else passed++;
            total++;
            if ({if8.cout, if8.s} !== e8)
                $display("FAIL sweep8[%0d]: got %h want %h",
                         i, {if8.cout, if8.s}, e8);
            else passed++;
            total++;
            if ({if1.cout, if1.s} !== e1)
                $display("FAIL sweep1[%0d]: got %b want %b",
                         i, {if1.cout, if1.s}, e1);
            else passed++;
        end
    endtask

    initial begin
        drive32(32'd0, 32'd0, 1'b0);
        if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_vectors("vec");
        test_back_to_back();
        test_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
